// File: rtl/sram_requester_pkg.sv
// Shared types and parameter-derivation helpers for the SRAM requester.
package sram_requester_pkg;

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_e;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int be_width(input int data_width, input int byte_width);
        return (data_width + byte_width - 1) / byte_width;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Shift-register response buffer: entry 0 is the registered output word.
module sram_rsp_fifo #(
    parameter int  Depth    = 2,
    parameter int  Width    = 128,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [Width-1:0]    data_i,
    output logic [Width-1:0]    data_o,
    output logic [CntWidth-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    logic [Depth-1:0][Width-1:0] r_mem;
    logic [CntWidth-1:0]         r_count;
    logic                        w_pop;
    logic [CntWidth-1:0]         w_wr_idx;

    assign w_pop    = pop_i && (r_count != '0);
    // A push that coincides with a pop lands one slot lower, after the shift.
    assign w_wr_idx = r_count - CntWidth'(w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem   <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < Depth - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            for (int i = 0; i < Depth; i++) begin
                if (push_i && (w_wr_idx == CntWidth'(i))) begin
                    r_mem[i] <= data_i;
                end
            end
            r_count <= r_count + CntWidth'(push_i) - CntWidth'(w_pop);
        end
    end

    assign data_o  = r_mem[0];
    assign count_o = r_count;
    assign full_o  = (r_count == CntWidth'(Depth));
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/sram_requester.sv
// Initiator for a single-port SRAM: command stream in, in-order read responses out.
// Define SRAM_REQUESTER_FILL_EN to write FillValue to every word after reset.
module sram_requester
    import sram_requester_pkg::*;
#(
    parameter int                   Depth       = 128,
    parameter int                   DataWidth   = 128,
    parameter int                   ByteWidth   = 8,
    parameter int                   RespDepth   = 2,
    parameter logic [DataWidth-1:0] FillValue   = '0,
    localparam int                  AddrWidth   = addr_width(Depth),
    localparam int                  ByteEnWidth = be_width(DataWidth, ByteWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [ByteEnWidth-1:0] cmd_be_i,
    input  logic [DataWidth-1:0]   cmd_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [ByteEnWidth-1:0] sram_be_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    input  logic [DataWidth-1:0]   sram_rdata_i,
    output logic                   busy_o
);

    localparam int CntWidth = $clog2(RespDepth + 1);

    logic                 w_fill;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_credit;
    logic                 w_empty;
    logic                 w_full;
    logic [AddrWidth-1:0] w_fill_addr;
    logic [DataWidth-1:0] w_fill_data;
    logic [CntWidth-1:0]  w_count;
    logic                 r_inflight;

    assign w_fill_data = FillValue;

`ifdef SRAM_REQUESTER_FILL_EN
    state_e               r_state;
    logic [AddrWidth-1:0] r_fill_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_FILL;
            r_fill_addr <= '0;
        end else if (r_state == ST_FILL) begin
            r_fill_addr <= r_fill_addr + AddrWidth'(1);
            if (r_fill_addr == AddrWidth'(Depth - 1)) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign w_fill      = (r_state == ST_FILL);
    assign w_fill_addr = r_fill_addr;
`else
    assign w_fill      = 1'b0;
    assign w_fill_addr = '0;
`endif

    assign busy_o      = w_fill;
    assign rsp_valid_o = !w_empty;
    assign w_pop       = rsp_valid_o && rsp_ready_i;
    // Outstanding reads (buffered + returning) after this cycle's pop must leave a free slot.
    assign w_credit    = (32'(w_count) + 32'(r_inflight)) < (32'(RespDepth) + 32'(w_pop));
    assign cmd_ready_o = !w_fill && (cmd_we_i || w_credit);
    assign w_accept    = cmd_valid_i && cmd_ready_o;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        if (w_fill) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = w_fill_addr;
            sram_be_o    = '1;
            sram_wdata_o = w_fill_data;
        end else if (w_accept) begin
            sram_req_o   = 1'b1;
            sram_we_o    = cmd_we_i;
            sram_addr_o  = cmd_addr_i;
            sram_be_o    = cmd_be_i;
            sram_wdata_o = cmd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept && !cmd_we_i;
        end
    end

    sram_rsp_fifo #(
        .Depth (RespDepth),
        .Width (DataWidth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (r_inflight),
        .pop_i   (w_pop),
        .data_i  (sram_rdata_i),
        .data_o  (rsp_rdata_o),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // The SRAM return cannot be stalled, so it must never meet a full buffer.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_inflight && w_full && !w_pop));

endmodule
